// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, state type and defaults for the data-memory controller
package mem_pkg;
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_INV  = 2'd3;
  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;
  localparam int BUS_TIMEOUT_DEF = 255;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store-data replication and load extraction/extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        ext,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        misaligned
);
  logic [31:0] sh;
  logic        sgn;
  always_comb begin
    sh = bus_rdata >> {addr_lo, 3'b000};
    sgn = ext == EXT_SIGN;
    be = size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
         size == SZ_BYTE ? 4'b0001 << addr_lo : 4'b1111;
    lane_wdata = size == SZ_HALF ? {2{wdata[15:0]}} :
                 size == SZ_BYTE ? {4{wdata[7:0]}} : wdata;
    ext_rdata = size == SZ_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} :
                size == SZ_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} : sh;
    misaligned = (size == SZ_WORD && addr_lo != 2'b00) || (size == SZ_HALF && addr_lo[0]);
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: executes byte/half/word loads and stores on a word bus, stalling until ack or timeout
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memDataSize,
  input  logic        memBitExt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        accErr,
  output logic        busErr,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWdata,
  input  logic [31:0] busRdata,
  input  logic        busAck
);
  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d, bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
  logic [1:0]  lo_q, lo_d, size_q, size_d;
  logic        ext_q, ext_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        idle, req, bad, go, mis, timeout;
  logic [3:0]  be;
  logic [31:0] lane_wdata, ext_rdata;
  assign idle = state_q == ST_IDLE;
  assign req = memRead | memWrite;
  assign bad = (memRead & memWrite) | (memDataSize == SZ_INV) | mis;
  assign go = idle & req & ~bad;
  assign timeout = (cnt_q == 8'(BUS_TIMEOUT - 1)) & ~busAck;
  // In IDLE the aligner sees the live request; afterwards it works on the latched one for load data
  mem_lane_align u_align (
    .addr_lo    (idle ? addr[1:0] : lo_q),
    .size       (idle ? memDataSize : size_q),
    .ext        (idle ? memBitExt : ext_q),
    .wdata      (wdata),
    .bus_rdata  (busRdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .ext_rdata  (ext_rdata),
    .misaligned (mis)
  );
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_be_d = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d = 1'b0;
    lo_d = lo_q;
    size_d = size_q;
    ext_d = ext_q;
    cnt_d = cnt_q;
    if (go) begin
      state_d = ST_ACCESS;
      bus_req_d = 1'b1;
      bus_we_d = memWrite;
      bus_addr_d = {addr[31:2], 2'b00};
      bus_be_d = be;
      bus_wdata_d = memWrite ? lane_wdata : '0;
      lo_d = addr[1:0];
      size_d = memDataSize;
      ext_d = memBitExt;
      cnt_d = '0;
    end else if (state_q == ST_ACCESS) begin
      cnt_d = cnt_q + 8'd1;
      if (busAck || timeout) begin
        state_d = ST_DONE;
        bus_req_d = 1'b0;
        bus_we_d = 1'b0;
        bus_addr_d = '0;
        bus_be_d = '0;
        bus_wdata_d = '0;
        bus_err_d = ~busAck;
        rdata_d = bus_we_q ? rdata_q : (busAck ? ext_rdata : '0);
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= '0;
      bus_be_q <= '0;
      bus_wdata_q <= '0;
      bus_err_q <= 1'b0;
      lo_q <= '0;
      size_q <= SZ_WORD;
      ext_q <= EXT_SIGN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_be_q <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q <= bus_err_d;
      lo_q <= lo_d;
      size_q <= size_d;
      ext_q <= ext_d;
      cnt_q <= cnt_d;
    end
  end
  assign stall = go | (state_q == ST_ACCESS);
  assign accErr = idle & req & bad;
  assign rdata = rdata_q;
  assign busErr = bus_err_q;
  assign busReq = bus_req_q;
  assign busWe = bus_we_q;
  assign busAddr = bus_addr_q;
  assign busBe = bus_be_q;
  assign busWdata = bus_wdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed load/store/error/timeout/reset scenarios checked every cycle against a behavioural model
module tb_data_mem_ctrl;
  localparam int T = 4;
  logic clk = 0, rst = 1, memRead = 0, memWrite = 0, memBitExt = 0, busAck = 0;
  logic [1:0] memDataSize = 0;
  logic [31:0] addr = 0, wdata = 0, busRdata = 0;
  logic [31:0] rdata, busAddr, busWdata;
  logic [3:0] busBe;
  logic stall, accErr, busErr, busReq, busWe;
  data_mem_ctrl #(.BUS_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .memDataSize(memDataSize),
    .memBitExt(memBitExt), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .accErr(accErr), .busErr(busErr), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busBe(busBe), .busWdata(busWdata), .busRdata(busRdata), .busAck(busAck)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 0;
  logic [31:0] e_rdata = 0, e_addr, e_wdata;
  logic [3:0] e_be;
  logic e_stall, e_acc, e_berr, e_req, e_we;
  int stall_cnt = 0, req_cnt = 0, berr_cnt = 0;
  logic [3:0] seen_be = 0;
  logic [31:0] seen_wdata = 0, seen_addr = 0;
  logic seen_we = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
    return sz == 2'd0 ? 4'hF : sz == 2'd1 ? 4'(3 << off) : 4'(1 << off);
  endfunction
  function automatic logic [31:0] f_lane(input logic [1:0] sz, input logic [31:0] wd);
    return sz == 2'd0 ? wd : sz == 2'd1 ? (wd & 32'hFFFF) * 32'h00010001 : (wd & 32'hFF) * 32'h01010101;
  endfunction
  function automatic logic [31:0] f_load(input logic [1:0] sz, input logic ext, input logic [1:0] off, input logic [31:0] bus);
    logic [31:0] v = bus >> (8 * off);
    int n = sz == 2'd1 ? 16 : sz == 2'd2 ? 8 : 32;
    if (n == 32) return v;
    v = v % (32'd1 << n);
    if (!ext && v >= (32'd1 << (n - 1))) v = v - (32'd1 << n);
    return v;
  endfunction
  function automatic bit f_bad(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
    return (rd && wr) || sz == 2'd3 || (sz == 2'd0 && a % 4 != 0) || (sz == 2'd1 && a % 2 != 0);
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("rdata", rdata, e_rdata);
    chk("stall", stall, e_stall);
    chk("accErr", accErr, e_acc);
    chk("busErr", busErr, e_berr);
    chk("busReq", busReq, e_req);
    chk("busWe", busWe, e_we);
    chk("busAddr", busAddr, e_addr);
    chk("busBe", busBe, e_be);
    chk("busWdata", busWdata, e_wdata);
    stall_cnt += int'(stall);
    req_cnt += int'(busReq);
    berr_cnt += int'(busErr);
    if (busReq) begin
      seen_be = busBe;
      seen_wdata = busWdata;
      seen_addr = busAddr;
      seen_we = busWe;
    end
  end
  task automatic set_idle();
    e_stall = 0; e_acc = 0; e_berr = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_cnt();
    stall_cnt = 0; req_cnt = 0; berr_cnt = 0;
  endtask
  // delay: ACCESS cycle index carrying the ack (-1 = never); rst_at: ACCESS cycle index for reset (-1 = none)
  task automatic xact(input logic rd, input logic wr, input logic [1:0] sz, input logic ext,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bus,
                      input int delay, input int rst_at);
    bit bad = f_bad(rd, wr, sz, a);
    bit acked = 0;
    int k = 0;
    step();
    memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext; addr = a; wdata = wd;
    busRdata = bus; busAck = 1;
    set_idle();
    e_stall = !bad;
    e_acc = bad;
    if (bad) begin
      step();
      memRead = 0; memWrite = 0; busAck = 0;
      set_idle();
      return;
    end
    while (!acked && k < T) begin
      step();
      busAck = (k == delay);
      if (k == rst_at) begin
        rst = 1; memRead = 0; memWrite = 0; busAck = 0;
        set_idle();
        e_rdata = 0;
        step();
        rst = 0;
        return;
      end
      e_stall = 1; e_req = 1; e_we = wr; e_addr = {a[31:2], 2'b00};
      e_be = f_be(sz, a[1:0]);
      e_wdata = wr ? f_lane(sz, wd) : 32'h0;
      acked = busAck;
      k++;
    end
    step();
    busAck = 1;
    set_idle();
    e_berr = !acked;
    if (rd) e_rdata = acked ? f_load(sz, ext, a[1:0], bus) : 32'h0;
    step();
    memRead = 0; memWrite = 0; busAck = 0;
    set_idle();
  endtask
  initial begin
    set_idle();
    e_rdata = 0;
    @(negedge clk);
    chk_en = 1;
    step();
    rst = 0;
    clear_cnt();
    xact(1, 0, 2'd0, 0, 32'h100, 0, 32'hDEADBEEF, 1, -1);
    chk("lw_stall_cycles", stall_cnt, 3);
    chk("lw_addr_lit", seen_addr, 32'h100);
    chk("lw_be_lit", seen_be, 4'b1111);
    chk("lw_rdata_lit", rdata, 32'hDEADBEEF);
    xact(1, 0, 2'd2, 0, 32'h103, 0, 32'h80123456, 0, -1);
    chk("lb_be_lit", seen_be, 4'b1000);
    chk("lb_rdata_lit", rdata, 32'hFFFFFF80);
    xact(1, 0, 2'd2, 1, 32'h103, 0, 32'h80123456, 0, -1);
    chk("lbu_rdata_lit", rdata, 32'h00000080);
    xact(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 0, 2, -1);
    chk("sh_be_lit", seen_be, 4'b1100);
    chk("sh_we_lit", seen_we, 1);
    chk("sh_wdata_lit", seen_wdata, 32'hABCDABCD);
    chk("sh_rdata_kept", rdata, 32'h00000080);
    clear_cnt();
    xact(1, 0, 2'd0, 0, 32'h101, 0, 0, 0, -1);
    xact(0, 1, 2'd1, 0, 32'h203, 32'h1234, 0, 0, -1);
    xact(1, 0, 2'd3, 0, 32'h0, 0, 0, 0, -1);
    xact(1, 1, 2'd0, 0, 32'h0, 0, 0, 0, -1);
    chk("rej_no_req", req_cnt, 0);
    chk("rej_no_stall", stall_cnt, 0);
    clear_cnt();
    xact(0, 1, 2'd0, 0, 32'h300, 32'hCAFEF00D, 0, -1, -1);
    chk("to_access_cycles", req_cnt, T);
    chk("to_buserr_pulses", berr_cnt, 1);
    clear_cnt();
    xact(1, 0, 2'd1, 0, 32'h102, 0, 32'h80010000, T - 1, -1);
    chk("ack_wins_no_err", berr_cnt, 0);
    chk("lh_rdata_lit", rdata, 32'hFFFF8001);
    xact(1, 0, 2'd1, 1, 32'h100, 0, 32'h1234F00D, 0, -1);
    chk("lhu_rdata_lit", rdata, 32'h0000F00D);
    xact(0, 1, 2'd2, 0, 32'h401, 32'h7777775A, 0, 0, -1);
    chk("sb_be_lit", seen_be, 4'b0010);
    chk("sb_wdata_lit", seen_wdata, 32'h5A5A5A5A);
    xact(1, 0, 2'd0, 0, 32'h104, 0, 32'h11111111, -1, -1);
    chk("to_rd_rdata_zero", rdata, 32'h0);
    xact(1, 0, 2'd0, 0, 32'h108, 0, 32'h55AA55AA, -1, 1);
    xact(1, 0, 2'd0, 0, 32'h0, 0, 32'h12345678, 0, -1);
    chk("post_rst_rdata_lit", rdata, 32'h12345678);
    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
